// File: rtl/switch_router.sv
// Ingress routing stage of the 4-port switch: holds the per-port address
// registers, routes each framed packet by its DA byte, checks the XOR FCS and counts drops.
module switch_router (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       mem_en,
  input  logic       mem_rd_wr,
  input  logic [1:0] mem_add,
  input  logic [7:0] mem_data,
  output logic [7:0] mem_rdata,
  input  logic       data_status,
  input  logic [7:0] data_in,
  output logic [3:0] port_valid,
  output logic [7:0] port_data,
  output logic       pkt_done,
  output logic       fcs_err,
  output logic       pkt_abort,
  output logic [7:0] drop_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SA,
    S_LEN,
    S_PAYLOAD,
    S_FCS
  } state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  addr_q [4];
  logic [3:0]  cfg_vld_q;
  logic [7:0]  mem_rdata_q;
  logic        drop_q, drop_d;
  logic [1:0]  dst_q, dst_d;
  logic [7:0]  fcs_acc_q, fcs_acc_d;
  logic [7:0]  remain_q, remain_d;
  logic [3:0]  port_valid_q, port_valid_d;
  logic [7:0]  port_data_q, port_data_d;
  logic        pkt_done_q, pkt_done_d;
  logic        fcs_err_q, fcs_err_d;
  logic        pkt_abort_q, pkt_abort_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;
  logic        hit;
  logic [1:0]  hit_idx;

  // DA lookup against the registered config, so a same-edge write is not seen.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (cfg_vld_q[i] && (addr_q[i] == data_in)) begin
        hit     = 1'b1;
        hit_idx = i[1:0];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    drop_d       = drop_q;
    dst_d        = dst_q;
    fcs_acc_d    = fcs_acc_q;
    remain_d     = remain_q;
    port_valid_d = 4'b0000;
    port_data_d  = port_data_q;
    pkt_done_d   = 1'b0;
    fcs_err_d    = 1'b0;
    pkt_abort_d  = 1'b0;
    drop_cnt_d   = drop_cnt_q;

    if (state_q == S_IDLE) begin
      if (data_status) begin
        dst_d        = hit_idx;
        drop_d       = !hit;
        fcs_acc_d    = data_in;
        port_data_d  = data_in;
        port_valid_d = hit ? onehot(hit_idx) : 4'b0000;
        state_d      = S_SA;
      end
    end else if (!data_status) begin
      pkt_abort_d = 1'b1;
      state_d     = S_IDLE;
    end else begin
      port_data_d  = data_in;
      port_valid_d = drop_q ? 4'b0000 : onehot(dst_q);
      fcs_acc_d    = fcs_acc_q ^ data_in;
      case (state_q)
        S_SA: state_d = S_LEN;
        S_LEN: begin
          remain_d = data_in;
          state_d  = (data_in == 8'd0) ? S_FCS : S_PAYLOAD;
        end
        S_PAYLOAD: begin
          remain_d = remain_q - 8'd1;
          if (remain_q == 8'd1) state_d = S_FCS;
        end
        S_FCS: begin
          fcs_acc_d  = fcs_acc_q;
          pkt_done_d = 1'b1;
          fcs_err_d  = (data_in != fcs_acc_q);
          if (drop_q) drop_cnt_d = sat_inc(drop_cnt_q);
          state_d    = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cfg_vld_q    <= 4'b0000;
      mem_rdata_q  <= 8'h00;
      drop_q       <= 1'b0;
      dst_q        <= 2'd0;
      port_valid_q <= 4'b0000;
      port_data_q  <= 8'h00;
      pkt_done_q   <= 1'b0;
      fcs_err_q    <= 1'b0;
      pkt_abort_q  <= 1'b0;
      drop_cnt_q   <= 8'h00;
      for (int i = 0; i < 4; i++) addr_q[i] <= 8'h00;
    end else begin
      state_q      <= state_d;
      drop_q       <= drop_d;
      dst_q        <= dst_d;
      port_valid_q <= port_valid_d;
      port_data_q  <= port_data_d;
      pkt_done_q   <= pkt_done_d;
      fcs_err_q    <= fcs_err_d;
      pkt_abort_q  <= pkt_abort_d;
      drop_cnt_q   <= drop_cnt_d;
      if (mem_en && mem_rd_wr) begin
        addr_q[mem_add]    <= mem_data;
        cfg_vld_q[mem_add] <= 1'b1;
      end
      if (mem_en && !mem_rd_wr) mem_rdata_q <= addr_q[mem_add];
    end
  end

  // Packet scratch state is only meaningful between DA and FCS.
  always_ff @(posedge clk) begin
    fcs_acc_q <= fcs_acc_d;
    remain_q  <= remain_d;
  end

  assign mem_rdata  = mem_rdata_q;
  assign port_valid = port_valid_q;
  assign port_data  = port_data_q;
  assign pkt_done   = pkt_done_q;
  assign fcs_err    = fcs_err_q;
  assign pkt_abort  = pkt_abort_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_switch_router.sv
// Directed bench for switch_router: inputs change and outputs are sampled on the falling edge.
module tb_switch_router;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       mem_en;
  logic       mem_rd_wr;
  logic [1:0] mem_add;
  logic [7:0] mem_data;
  logic [7:0] mem_rdata;
  logic       data_status;
  logic [7:0] data_in;
  logic [3:0] port_valid;
  logic [7:0] port_data;
  logic       pkt_done;
  logic       fcs_err;
  logic       pkt_abort;
  logic [7:0] drop_cnt;

  int checks   = 0;
  int failures = 0;
  logic [7:0] pl [16];

  switch_router dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .mem_en      (mem_en),
    .mem_rd_wr   (mem_rd_wr),
    .mem_add     (mem_add),
    .mem_data    (mem_data),
    .mem_rdata   (mem_rdata),
    .data_status (data_status),
    .data_in     (data_in),
    .port_valid  (port_valid),
    .port_data   (port_data),
    .pkt_done    (pkt_done),
    .fcs_err     (fcs_err),
    .pkt_abort   (pkt_abort),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle; on return the registered response to this cycle is visible.
  task automatic step(input logic ds, input logic [7:0] din);
    data_status = ds;
    data_in     = din;
    @(negedge clk);
  endtask

  task automatic cfg_wr(input logic [1:0] a, input logic [7:0] d);
    mem_en = 1'b1; mem_rd_wr = 1'b1; mem_add = a; mem_data = d;
    step(1'b0, 8'h00);
    mem_en = 1'b0;
  endtask

  task automatic cfg_rd(input logic [1:0] a, input logic [7:0] exp, input string tag);
    mem_en = 1'b1; mem_rd_wr = 1'b0; mem_add = a;
    step(1'b0, 8'h00);
    mem_en = 1'b0;
    chk(tag, mem_rdata, exp);
  endtask

  // Sends DA,SA,LEN,pl[0..len-1],FCS back to back. exp_port<0 means dropped.
  // cfg_at>=0 performs a config write while that byte index is presented.
  task automatic send_pkt(input string tag, input logic [7:0] da, input logic [7:0] sa,
                          input int len, input logic [7:0] fcs, input int exp_port,
                          input logic exp_err, input bit quiet,
                          input int cfg_at, input logic [1:0] cfg_a, input logic [7:0] cfg_d);
    logic [7:0] b;
    logic [3:0] vexp;
    int n;
    n    = len + 4;
    vexp = (exp_port < 0) ? 4'b0000 : (4'b0001 << exp_port);
    for (int k = 0; k < n; k++) begin
      if (k == 0)          b = da;
      else if (k == 1)     b = sa;
      else if (k == 2)     b = len[7:0];
      else if (k == n - 1) b = fcs;
      else                 b = pl[k - 3];
      if (k == cfg_at) begin
        mem_en = 1'b1; mem_rd_wr = 1'b1; mem_add = cfg_a; mem_data = cfg_d;
      end
      step(1'b1, b);
      mem_en = 1'b0;
      if (!quiet) begin
        chk($sformatf("%s valid[%0d]", tag, k), port_valid, vexp);
        if (exp_port >= 0) chk($sformatf("%s data[%0d]", tag, k), port_data, b);
        chk($sformatf("%s done[%0d]", tag, k), pkt_done, (k == n - 1));
        if (k == n - 1) chk($sformatf("%s fcs_err", tag), fcs_err, exp_err);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; mem_en = 1'b0; mem_rd_wr = 1'b0; mem_add = 2'd0; mem_data = 8'h00;
    data_status = 1'b0; data_in = 8'h00;
    @(negedge clk);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    chk("rst port_valid", port_valid, 4'b0000);
    chk("rst port_data", port_data, 8'h00);
    chk("rst mem_rdata", mem_rdata, 8'h00);
    chk("rst drop_cnt", drop_cnt, 8'h00);
    chk("rst pulses", {pkt_done, fcs_err, pkt_abort}, 3'b000);
    reset_n = 1'b1;
    step(1'b0, 8'h00);

    // Unconfigured: DA 0x00 must not match a cleared register.
    send_pkt("unconf", 8'h00, 8'h01, 0, 8'h01, -1, 1'b0, 1'b0, -1, 2'd0, 8'h00);
    step(1'b0, 8'h00);
    chk("unconf drop_cnt", drop_cnt, 8'd1);

    cfg_wr(2'd0, 8'h10);
    cfg_wr(2'd1, 8'h20);
    cfg_wr(2'd2, 8'h30);
    cfg_wr(2'd3, 8'h40);
    cfg_rd(2'd3, 8'h40, "rd addr3");

    pl[0] = 8'hAA; pl[1] = 8'h55;
    send_pkt("route", 8'h30, 8'h01, 2, 8'hCC, 2, 1'b0, 1'b0, -1, 2'd0, 8'h00);
    step(1'b0, 8'h00);
    chk("route idle valid", port_valid, 4'b0000);
    chk("route idle done", pkt_done, 1'b0);

    cfg_wr(2'd2, 8'h5A);
    cfg_rd(2'd2, 8'h5A, "rd addr2");
    cfg_wr(2'd2, 8'h30);

    send_pkt("len0", 8'h40, 8'h07, 0, 8'h47, 3, 1'b0, 1'b0, -1, 2'd0, 8'h00);
    send_pkt("len0bad", 8'h40, 8'h07, 0, 8'h46, 3, 1'b1, 1'b0, -1, 2'd0, 8'h00);
    step(1'b0, 8'h00);
    chk("len0bad clears", {pkt_done, fcs_err}, 2'b00);

    // Abort after the 3rd payload byte of a LEN=8 packet.
    step(1'b1, 8'h10); step(1'b1, 8'h02); step(1'b1, 8'h08);
    step(1'b1, 8'h01); step(1'b1, 8'h02); step(1'b1, 8'h03);
    chk("pre-abort valid", port_valid, 4'b0001);
    step(1'b0, 8'h00);
    chk("abort pulse", pkt_abort, 1'b1);
    chk("abort no done", pkt_done, 1'b0);
    chk("abort no fwd", port_valid, 4'b0000);
    step(1'b0, 8'h00);
    chk("abort pulse end", pkt_abort, 1'b0);
    chk("abort drop_cnt", drop_cnt, 8'd1);

    pl[0] = 8'h5A;
    send_pkt("b2b1", 8'h20, 8'h03, 1, 8'h78, 1, 1'b0, 1'b0, -1, 2'd0, 8'h00);
    pl[0] = 8'h01; pl[1] = 8'h02;
    send_pkt("b2b2", 8'h10, 8'h04, 2, 8'h15, 0, 1'b0, 1'b0, -1, 2'd0, 8'h00);
    step(1'b0, 8'h00);

    // addr1 rewritten while its packet is in flight.
    pl[0] = 8'h11;
    send_pkt("rewr", 8'h20, 8'h05, 1, 8'h35, 1, 1'b0, 1'b0, 1, 2'd1, 8'h99);
    step(1'b0, 8'h00);
    send_pkt("rewr after", 8'h20, 8'h00, 0, 8'h20, -1, 1'b0, 1'b0, -1, 2'd0, 8'h00);
    step(1'b0, 8'h00);
    chk("rewr drop_cnt", drop_cnt, 8'd2);

    for (int p = 0; p < 252; p++)
      send_pkt("sat", 8'h00, 8'h00, 0, 8'h00, -1, 1'b0, 1'b1, -1, 2'd0, 8'h00);
    step(1'b0, 8'h00);
    chk("drop_cnt FE", drop_cnt, 8'hFE);
    for (int p = 0; p < 3; p++)
      send_pkt("sat", 8'h00, 8'h00, 0, 8'h00, -1, 1'b0, 1'b1, -1, 2'd0, 8'h00);
    step(1'b0, 8'h00);
    chk("drop_cnt sat", drop_cnt, 8'hFF);

    // Reset in the middle of a routed packet.
    cfg_rd(2'd0, 8'h10, "rd addr0 pre");
    step(1'b1, 8'h10); step(1'b1, 8'h06);
    reset_n = 1'b0;
    step(1'b1, 8'h01);
    chk("mid rst valid", port_valid, 4'b0000);
    chk("mid rst data", port_data, 8'h00);
    chk("mid rst rdata", mem_rdata, 8'h00);
    chk("mid rst drop_cnt", drop_cnt, 8'h00);
    chk("mid rst pulses", {pkt_done, fcs_err, pkt_abort}, 3'b000);
    reset_n = 1'b1;
    step(1'b0, 8'h00);
    chk("post rst abort", pkt_abort, 1'b0);
    cfg_rd(2'd0, 8'h00, "rd addr0 cleared");
    send_pkt("post rst", 8'h00, 8'h01, 0, 8'h01, -1, 1'b0, 1'b0, -1, 2'd0, 8'h00);
    step(1'b0, 8'h00);
    chk("post rst drop_cnt", drop_cnt, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
